// File: rtl/ysyx_22040386_branch_unit.sv
// Branch resolution unit: resolves taken/not-taken, issues redirects to fetch
// through a valid/ready handshake, and keeps a 2^IDX_W-entry saturating-counter BHT.
module ysyx_22040386_branch_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [2:0]      ex_branch_type,
  input  logic            zero,
  input  logic            result0,
  input  logic            jal,
  input  logic            jalr,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pc_plus4,
  output logic            branch,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            ex_stall,
  output logic [31:0]     mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] bht_q [ENTRIES];
  logic [CNT_W-1:0] bht_d [ENTRIES];
  logic             redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             cond, uncond, accept, mispredict;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             unused_pc_bits;

  assign rd_idx = pred_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    case (ex_branch_type)
      3'b000:         cond = zero;
      3'b001:         cond = ~zero;
      3'b100, 3'b110: cond = result0;
      3'b101, 3'b111: cond = ~result0;
      default:        cond = 1'b0;
    endcase
  end

  assign uncond     = jal | jalr | ecall | mret;
  assign branch     = ex_valid & (uncond | (ex_is_br & cond));
  assign ex_stall   = redir_valid_q & ~redir_ready;
  assign accept     = ex_valid & ~ex_stall;
  assign mispredict = accept & ((ex_is_br & (branch != ex_pred_taken)) | uncond);
  assign pred_taken = bht_q[rd_idx][CNT_W-1];

  // A new mispredict wins over the handshake clearing the pending redirect.
  always_comb begin
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    cnt_d         = cnt_q;
    if (mispredict) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = branch ? ex_target : ex_pc_plus4;
      cnt_d         = cnt_q + 32'd1;
    end else if (redir_ready) begin
      redir_valid_d = 1'b0;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (accept && ex_is_br) begin
      if (branch) begin
        if (bht_q[wr_idx] != CNT_MAX) bht_d[wr_idx] = bht_q[wr_idx] + 1'b1;
      end else begin
        if (bht_q[wr_idx] != '0) bht_d[wr_idx] = bht_q[wr_idx] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      cnt_q         <= '0;
    end else begin
      bht_q         <= bht_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign redir_valid    = redir_valid_q;
  assign redir_pc       = redir_pc_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_branch_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_ysyx_22040386_branch_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int          NENT  = 16;
  localparam int          CMAX  = 3;

  logic            clk, rst;
  logic [XLEN-1:0] pred_pc, ex_pc, ex_target, ex_pc_plus4, redir_pc;
  logic            pred_taken, ex_valid, ex_is_br, ex_pred_taken;
  logic [2:0]      ex_branch_type;
  logic            zero, result0, jal, jalr, ecall, mret;
  logic            branch, redir_valid, redir_ready, ex_stall;
  logic [31:0]     mispredict_cnt;

  ysyx_22040386_branch_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_branch_type(ex_branch_type),
    .zero(zero), .result0(result0), .jal(jal), .jalr(jalr), .ecall(ecall),
    .mret(mret), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
    .branch(branch), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .ex_stall(ex_stall), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // ---------------- behavioural model ----------------
  int          m_bht [NENT];
  bit          m_rv;
  logic [63:0] m_rpc;
  logic [31:0] m_cnt;

  function automatic bit m_cond(input logic [2:0] t, input logic z, input logic r0);
    case (t)
      3'd0:       return z;
      3'd1:       return !z;
      3'd4, 3'd6: return r0;
      3'd5, 3'd7: return !r0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit m_branch();
    return ex_valid && (jal || jalr || ecall || mret || (ex_is_br && m_cond(ex_branch_type, zero, result0)));
  endfunction

  bit u_acc, u_br, u_misp;
  int u_idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) m_bht[i] = 1;
      m_rv = 0; m_rpc = '0; m_cnt = '0;
    end else begin
      u_acc  = ex_valid && !(m_rv && !redir_ready);
      u_br   = m_branch();
      u_misp = u_acc && ((ex_is_br && (u_br != ex_pred_taken)) || jal || jalr || ecall || mret);
      if (u_acc && ex_is_br) begin
        u_idx = int'(ex_pc[5:2]);
        if (u_br) m_bht[u_idx] = (m_bht[u_idx] < CMAX) ? m_bht[u_idx] + 1 : CMAX;
        else      m_bht[u_idx] = (m_bht[u_idx] > 0) ? m_bht[u_idx] - 1 : 0;
      end
      if (u_misp) begin
        m_rv = 1; m_rpc = u_br ? ex_target : ex_pc_plus4; m_cnt = m_cnt + 1;
      end else if (redir_ready) begin
        m_rv = 0;
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("branch",         branch,         m_branch());
    chk("ex_stall",       ex_stall,       m_rv && !redir_ready);
    chk("pred_taken",     pred_taken,     m_bht[int'(pred_pc[5:2])] >= 2);
    chk("redir_valid",    redir_valid,    m_rv);
    chk("redir_pc",       redir_pc,       m_rpc);
    chk("mispredict_cnt", mispredict_cnt, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_br = 0; ex_pred_taken = 0; ex_branch_type = 3'd0;
    zero = 0; result0 = 0; jal = 0; jalr = 0; ecall = 0; mret = 0;
  endtask

  task automatic set_br(input logic [63:0] pc, input logic [2:0] t, input logic z,
                        input logic pt, input logic [63:0] tgt);
    idle();
    ex_valid = 1; ex_is_br = 1; ex_pc = pc; ex_branch_type = t; zero = z;
    ex_pred_taken = pt; ex_target = tgt; ex_pc_plus4 = pc + 64'd4;
  endtask

  initial begin
    rst = 1; idle(); redir_ready = 1;
    pred_pc = '0; ex_pc = '0; ex_target = '0; ex_pc_plus4 = '0;
    repeat (2) tick();
    rst = 0;
    pred_pc = {$urandom, $urandom};
    @(negedge clk);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_cnt", mispredict_cnt, 0);

    // beq taken, predicted not-taken
    tick(); set_br(64'h8000_0000, 3'd0, 1, 0, 64'h8000_0100);
    @(negedge clk); chk("beq_branch", branch, 1);
    tick(); idle(); pred_pc = 64'h8000_0000;
    @(negedge clk);
    chk("beq_redir_valid", redir_valid, 1);
    chk("beq_redir_pc", redir_pc, 64'h8000_0100);
    chk("beq_cnt", mispredict_cnt, 1);
    chk("ctr10_pred", pred_taken, 1);

    // two more taken (predicted taken) -> saturate at 11
    tick(); set_br(64'h8000_0000, 3'd0, 1, 1, 64'h8000_0100);
    tick(); tick(); idle();
    @(negedge clk); chk("ctr11_pred", pred_taken, 1);
    // not-taken -> 10, still taken-predicted; redirect to fall-through
    tick(); set_br(64'h8000_0000, 3'd0, 0, 1, 64'h8000_0100);
    tick(); idle();
    @(negedge clk);
    chk("ctr10b_pred", pred_taken, 1);
    chk("nt_redir_pc", redir_pc, 64'h8000_0004);
    chk("nt_cnt", mispredict_cnt, 2);
    tick(); set_br(64'h8000_0000, 3'd0, 0, 1, 64'h8000_0100);
    tick(); idle();
    @(negedge clk); chk("ctr01_pred", pred_taken, 0);

    // stall: pending redirect, ready low for 3 cycles
    tick(); idle(); ex_valid = 1; jal = 1; ex_target = 64'h8000_0300;
    tick(); redir_ready = 0; set_br(64'h8000_0010, 3'd0, 1, 0, 64'h8000_0900);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_flag", ex_stall, 1);
      chk("stall_redir_pc", redir_pc, 64'h8000_0300);
      chk("stall_cnt", mispredict_cnt, 4);
      tick();
    end
    idle(); redir_ready = 1; pred_pc = 64'h8000_0010;
    @(negedge clk);
    chk("stall_no_bht", pred_taken, 0);
    chk("stall_hold_valid", redir_valid, 1);
    tick();
    @(negedge clk); chk("stall_clear", redir_valid, 0);

    // back-to-back: jal then jalr while handshaking
    tick(); idle(); ex_valid = 1; jal = 1; ex_target = 64'h8000_0400;
    tick(); idle(); ex_valid = 1; jalr = 1; ex_target = 64'h8000_0200;
    @(negedge clk); chk("b2b_first_pc", redir_pc, 64'h8000_0400);
    tick(); idle();
    @(negedge clk);
    chk("b2b_valid", redir_valid, 1);
    chk("b2b_pc", redir_pc, 64'h8000_0200);
    chk("b2b_cnt", mispredict_cnt, 6);

    // correctly predicted bne
    tick(); set_br(64'h8000_0020, 3'd1, 0, 1, 64'h8000_0700);
    @(negedge clk); chk("bne_branch", branch, 1);
    tick(); idle(); pred_pc = 64'h8000_0020;
    @(negedge clk);
    chk("bne_no_redir", redir_valid, 0);
    chk("bne_cnt", mispredict_cnt, 6);
    chk("bne_ctr_inc", pred_taken, 1);

    // reset mid-handshake
    tick(); idle(); ex_valid = 1; jal = 1; ex_target = 64'h8000_0500;
    tick(); idle(); redir_ready = 0;
    @(negedge clk); chk("pre_rst_valid", redir_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", redir_valid, 0);
    chk("async_rst_pc", redir_pc, 0);
    chk("async_rst_cnt", mispredict_cnt, 0);
    for (int i = 0; i < NENT; i++) begin
      #1 pred_pc = 64'(i) << 2;
      @(negedge clk); chk("rst_all_ctr", pred_taken, 0);
    end
    tick(); rst = 0; redir_ready = 1;

    // randomized run
    repeat (3000) begin
      int u;
      tick();
      rst = ($urandom % 300) == 0;
      idle();
      ex_valid = ($urandom % 10) < 7;
      ex_is_br = $urandom % 2;
      ex_branch_type = 3'($urandom % 8);
      zero = $urandom % 2; result0 = $urandom % 2;
      ex_pred_taken = $urandom % 2;
      u = int'($urandom % 16);
      jal = (u == 0); jalr = (u == 1); ecall = (u == 2); mret = (u == 3);
      ex_pc = 64'h8000_0000 + 64'(($urandom % 16) * 4);
      pred_pc = 64'h8000_0000 + 64'(($urandom % 16) * 4);
      ex_target = {$urandom, $urandom};
      ex_pc_plus4 = {$urandom, $urandom};
      redir_ready = ($urandom % 10) < 6;
    end
    tick(); rst = 0; idle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
